// File: rtl/mult_pkg.sv
// Shared widths and operand/product types for the 2-bit multiplier family.
package mult_pkg;

  localparam int unsigned OP_W   = 2;
  localparam int unsigned PROD_W = 4;

  typedef logic signed [OP_W-1:0]   operand_t;
  typedef logic signed [PROD_W-1:0] product_t;

endpackage : mult_pkg

// File: rtl/exact_mult_2bit_if.sv
// Operand/product bundle for exact_mult_2bit.
//   a, b      : signed 2-bit operands (master -> slave)
//   in_valid  : qualifies a/b for the registered path (master -> slave)
//   y         : combinational signed product (slave -> master)
//   y_q       : registered product, one-cycle latency (slave -> master)
//   out_valid : registered in_valid, aligned with y_q (slave -> master)
interface exact_mult_2bit_if;
  import mult_pkg::*;

  operand_t a;
  operand_t b;
  logic     in_valid;
  product_t y;
  product_t y_q;
  logic     out_valid;

  modport master (output a, b, in_valid, input y, y_q, out_valid);
  modport slave  (input a, b, in_valid, output y, y_q, out_valid);

endinterface : exact_mult_2bit_if

// File: rtl/fa_cell.sv
// 1-bit full adder; used as a half adder with cin tied low.
//   x, y, cin : addend bits
//   s, cout   : sum and carry out
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = x ^ y;
  assign s    = p ^ cin;
  assign cout = (x & y) | (cin & p);

endmodule : fa_cell

// File: rtl/exact_mult_2bit.sv
// Exact signed 2x2 -> 4-bit multiplier with combinational and registered outputs.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of exact_mult_2bit_if (a, b, in_valid -> y, y_q, out_valid)
module exact_mult_2bit
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  exact_mult_2bit_if.slave  bus
);

  logic     pp00, pp10, pp01, pp11;
  logic     s1, c1, s2, c2;
  product_t y_c;
  product_t y_q_q, y_q_d;
  logic     out_valid_q, out_valid_d;

  // Partial products; pp10 and pp01 carry negative weight (-2).
  assign pp00 = bus.a[0] & bus.b[0];
  assign pp10 = bus.a[1] & bus.b[0];
  assign pp01 = bus.a[0] & bus.b[1];
  assign pp11 = bus.a[1] & bus.b[1];

  // -2*pp = 2*~pp - 2, so the two negative terms contribute 2*(~pp10 + ~pp01)
  // plus a constant -4, which is +1100 modulo 16: ones injected at bits 2 and 3.
  fa_cell u_ha_col1 (
    .x    (~pp10),
    .y    (~pp01),
    .cin  (1'b0),
    .s    (s1),
    .cout (c1)
  );

  fa_cell u_fa_col2 (
    .x    (pp11),
    .y    (c1),
    .cin  (1'b1),
    .s    (s2),
    .cout (c2)
  );

  // Column 3 is c2 plus the correction one; carry out of bit 3 is discarded.
  assign y_c   = {~c2, s2, s1, pp00};
  assign bus.y = y_c;

  // Next-state for the registered copy: load only on qualified input.
  always_comb begin
    y_q_d       = y_q_q;
    out_valid_d = bus.in_valid;
    if (bus.in_valid) begin
      y_q_d = y_c;
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      y_q_q       <= y_q_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.y_q       = y_q_q;
  assign bus.out_valid = out_valid_q;

  // Reference check of the adder array against native signed multiply.
  always_comb begin
    if (!$isunknown({bus.a, bus.b})) begin
      assert (y_c == product_t'(bus.a) * product_t'(bus.b));
    end
  end

endmodule : exact_mult_2bit

// File: tb/tb_exact_mult_2bit.sv
// Directed and constrained-random checks for exact_mult_2bit.
module tb_exact_mult_2bit;
  import mult_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  exact_mult_2bit_if bus ();

  exact_mult_2bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Hand-computed products indexed by {a,b}.
  logic [3:0] exp_tab [16];

  initial begin
    int       ai, bi, iv;
    logic [3:0] yq_model;

    n_cmp = 0;
    n_err = 0;
    exp_tab = '{4'b0000, 4'b0000, 4'b0000, 4'b0000,   // a=00
                4'b0000, 4'b0001, 4'b1110, 4'b1111,   // a=01
                4'b0000, 4'b1110, 4'b0100, 4'b0010,   // a=10
                4'b0000, 4'b1111, 4'b0010, 4'b0001};  // a=11

    // Reset state; y is live during reset.
    rst_n        = 1'b0;
    bus.a        = 2'b01;
    bus.b        = 2'b10;
    bus.in_valid = 1'b0;
    #2;
    check("rst_y_q", bus.y_q, 4'b0000);
    check("rst_out_valid", {3'b000, bus.out_valid}, 4'b0000);
    check("rst_y_comb", bus.y, 4'b1110);
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive sweep through both paths.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.a        = operand_t'(i >> 2);
      bus.b        = operand_t'(i & 3);
      bus.in_valid = 1'b1;
      #1;
      check($sformatf("sweep_y_%0d", i), bus.y, exp_tab[i]);
      @(posedge clk);
      #1;
      check($sformatf("sweep_y_q_%0d", i), bus.y_q, exp_tab[i]);
      check($sformatf("sweep_ov_%0d", i), {3'b000, bus.out_valid}, 4'b0001);
    end

    // Random operands in {-1,0,1} with random qualification.
    yq_model = exp_tab[15];
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      ai = int'($urandom_range(2)) - 1;
      bi = int'($urandom_range(2)) - 1;
      iv = int'($urandom_range(1));
      bus.a        = operand_t'(ai);
      bus.b        = operand_t'(bi);
      bus.in_valid = iv[0];
      #1;
      check("rand_y", bus.y, 4'(ai * bi));
      if (iv != 0) yq_model = 4'(ai * bi);
      @(posedge clk);
      #1;
      check("rand_y_q", bus.y_q, yq_model);
      check("rand_ov", {3'b000, bus.out_valid}, 4'(iv));
    end

    // (-1)*(-1) loaded with in_valid.
    @(negedge clk);
    bus.a = 2'b11; bus.b = 2'b11; bus.in_valid = 1'b1;
    #1;
    check("m1m1_y", bus.y, 4'b0001);
    @(posedge clk);
    #1;
    check("m1m1_y_q", bus.y_q, 4'b0001);
    check("m1m1_ov", {3'b000, bus.out_valid}, 4'b0001);

    // in_valid low: y tracks, y_q holds, out_valid drops.
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = 2'b01; bus.b = 2'b11;
    #1;
    check("hold_y_a", bus.y, 4'b1111);
    bus.a = 2'b10; bus.b = 2'b01;
    #1;
    check("hold_y_b", bus.y, 4'b1110);
    @(posedge clk);
    #1;
    check("hold_y_q", bus.y_q, 4'b0001);
    check("hold_ov", {3'b000, bus.out_valid}, 4'b0000);

    // Load +4, then assert reset between edges.
    @(negedge clk);
    bus.a = 2'b10; bus.b = 2'b10; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("p4_y_q", bus.y_q, 4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_y_q", bus.y_q, 4'b0000);
    check("async_rst_ov", {3'b000, bus.out_valid}, 4'b0000);
    check("async_rst_y", bus.y, 4'b0100);

    // Release reset with a qualified 1 * -2.
    @(negedge clk);
    bus.a = 2'b01; bus.b = 2'b10; bus.in_valid = 1'b1;
    rst_n = 1'b1;
    #1;
    check("rel_y_q_pre", bus.y_q, 4'b0000);
    @(posedge clk);
    #1;
    check("rel_y_q", bus.y_q, 4'b1110);
    check("rel_ov", {3'b000, bus.out_valid}, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_exact_mult_2bit
